// File: rtl/instrumented_adder_ring_counter_pkg.sv
// Shared types and constants for the instrumented ripple adder measurement back-end.
package instrumented_adder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } ring_cnt_state_t;

  localparam int DEF_COUNT_W     = 32;
  localparam int DEF_TIME_W      = 32;
  localparam int DEF_SYNC_STAGES = 2;

  // Pipeline fill time of the chain_out synchroniser plus the edge-history flop.
  localparam int RING_SETTLE_CYCLES = DEF_SYNC_STAGES + 1;

endpackage

// File: rtl/instrumented_adder_ring_counter_if.sv
// Start/done handshake and result bus of the ring-oscillator edge counter.
interface instrumented_adder_ring_counter_if #(
  parameter int COUNT_W = instrumented_adder_pkg::DEF_COUNT_W,
  parameter int TIME_W  = instrumented_adder_pkg::DEF_TIME_W
);
  logic               start;
  logic [TIME_W-1:0]  window;
  logic               ring_en;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] count;
  logic               overflow;

  modport master (
    output start, window,
    input  ring_en, busy, done, count, overflow
  );

  modport slave (
    input  start, window,
    output ring_en, busy, done, count, overflow
  );
endinterface

// File: rtl/instrumented_adder_ring_counter_sync_rise_detect.sv
// N-stage synchroniser for an asynchronous input followed by a one-cycle rising-edge detector.
module sync_rise_detect
  import instrumented_adder_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/instrumented_adder_ring_counter.sv
// Gates the adder ring oscillator for a programmed window and reports a saturating
// count of chain_out rising edges with a start/done handshake.
module instrumented_adder_ring_counter
  import instrumented_adder_pkg::*;
#(
  parameter int COUNT_W     = DEF_COUNT_W,
  parameter int TIME_W      = DEF_TIME_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic chain_out,
  instrumented_adder_ring_counter_if.slave bus
);

  // Settle length tracks the synchroniser depth actually instantiated.
  localparam int SETTLE_N = RING_SETTLE_CYCLES + (SYNC_STAGES - DEF_SYNC_STAGES);
  localparam int SETTLE_W = $clog2(SETTLE_N);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_N - 1);
  localparam logic [COUNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [TIME_W-1:0]   WIN_LAST    = TIME_W'(1);

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  ring_cnt_state_t     state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [TIME_W-1:0]   win_q, win_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic [COUNT_W-1:0]  cnt_inc;
  logic                ovf_q, ovf_d;
  logic                ring_en_q, ring_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rise;

  sync_rise_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .async_in (chain_out),
    .rise     (rise)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    cnt_inc  = sat_inc(cnt_q);

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          cnt_d = '0;
          ovf_d = 1'b0;
          if (bus.window != '0) begin
            win_d    = bus.window;
            settle_d = SETTLE_LAST;
            state_d  = SETTLE;
          end else begin
            state_d = DONE;
          end
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = COUNT;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      COUNT: begin
        if (rise) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) ovf_d = 1'b1;
        end
        // Down-counter stops at 1 so a nonzero load can never wrap.
        if (win_q == WIN_LAST) begin
          state_d = DONE;
        end else begin
          win_d = win_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    ring_en_d = (state_d == SETTLE) || (state_d == COUNT);
    busy_d    = ring_en_d;
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      ring_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      ring_en_q <= ring_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.ring_en  = ring_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = cnt_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_instrumented_adder_ring_counter.sv
// Directed bench for the ring edge counter: a 32-bit instance and a 4-bit instance share stimulus.
`timescale 1ns/1ps
module tb_instrumented_adder_ring_counter;

  logic clk = 1'b0;
  logic rst;
  logic chain_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instrumented_adder_ring_counter_if #(.COUNT_W(32), .TIME_W(32)) bus ();
  instrumented_adder_ring_counter_if #(.COUNT_W(4),  .TIME_W(32)) bus_s ();

  instrumented_adder_ring_counter #(
    .COUNT_W(32), .TIME_W(32), .SYNC_STAGES(2)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .chain_out (chain_out),
    .bus       (bus)
  );

  instrumented_adder_ring_counter #(
    .COUNT_W(4), .TIME_W(32), .SYNC_STAGES(2)
  ) dut_s (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .chain_out (chain_out),
    .bus       (bus_s)
  );

  // Ring stand-in: square wave with a 4-clock period, changing away from the active edge.
  initial begin
    logic [1:0] ph;
    ph        = 2'd0;
    chain_out = 1'b0;
    forever begin
      @(negedge clk);
      ph        = ph + 2'd1;
      chain_out = ph[1];
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic drive_start(input bit s, input int w);
    bus.start    = s;
    bus_s.start  = s;
    bus.window   = w;
    bus_s.window = w;
  endtask

  // Called with start already raised; counts cycles after the accept edge until done.
  task automatic measure(input int w, input bit ign, input bit chain, input int chain_w,
                         output int done_cyc, output int done_cyc_s,
                         output int ring_cyc, output int busy_cyc);
    done_cyc   = 0;
    done_cyc_s = 0;
    ring_cyc   = 0;
    busy_cyc   = 0;
    for (int c = 1; c <= w + 20; c++) begin
      @(posedge clk); #1;
      drive_start(ign && (c == 5 || c == 20), w);
      if (bus.ring_en) ring_cyc++;
      if (bus.busy)    busy_cyc++;
      if (bus_s.done && done_cyc_s == 0) done_cyc_s = c;
      if (bus.done) begin
        done_cyc = c;
        break;
      end
    end
    if (chain) drive_start(1'b1, chain_w);
  endtask

  task automatic idle(input int n, output int pulses, output int ring_seen);
    pulses    = 0;
    ring_seen = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus_s.done)       pulses++;
      if (bus.ring_en || bus_s.ring_en) ring_seen++;
    end
  endtask

  initial begin
    int d, ds, r, b, p, rs;

    rst = 1'b1;
    drive_start(1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ring_en",  bus.ring_en,  0);
    check("rst_busy",     bus.busy,     0);
    check("rst_done",     bus.done,     0);
    check("rst_count",    bus.count,    0);
    check("rst_overflow", bus.overflow, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic count: W=40, S=3
    drive_start(1'b1, 40);
    measure(40, 1'b0, 1'b0, 0, d, ds, r, b);
    check("basic_done_cyc",   d, 44);
    check("basic_done_cyc_s", ds, 44);
    check("basic_ring_cyc",   r, 43);
    check("basic_busy_cyc",   b, 43);
    check("basic_count",      bus.count, 10);
    check("basic_overflow",   bus.overflow, 0);
    check("basic_count_s",    bus_s.count, 10);
    idle(5, p, rs);
    check("basic_count_hold", bus.count, 10);
    check("basic_extra_done", p, 0);

    // Zero window
    drive_start(1'b1, 0);
    measure(0, 1'b0, 1'b0, 0, d, ds, r, b);
    check("zero_done_cyc", d, 1);
    check("zero_ring_cyc", r, 0);
    check("zero_count",    bus.count, 0);
    check("zero_overflow", bus.overflow, 0);
    idle(5, p, rs);
    check("zero_ring_after", rs, 0);

    // Saturation on the 4-bit instance, 32-bit instance counts through
    drive_start(1'b1, 100);
    measure(100, 1'b0, 1'b0, 0, d, ds, r, b);
    check("sat_done_cyc",   d, 104);
    check("sat_count_s",    bus_s.count, 15);
    check("sat_overflow_s", bus_s.overflow, 1);
    check("sat_count",      bus.count, 25);
    check("sat_overflow",   bus.overflow, 0);
    idle(3, p, rs);
    drive_start(1'b1, 8);
    measure(8, 1'b0, 1'b0, 0, d, ds, r, b);
    check("sat2_done_cyc",   d, 12);
    check("sat2_count_s",    bus_s.count, 2);
    check("sat2_overflow_s", bus_s.overflow, 0);
    idle(3, p, rs);

    // Start pulses inside SETTLE/COUNT are ignored
    drive_start(1'b1, 40);
    measure(40, 1'b1, 1'b0, 0, d, ds, r, b);
    check("ign_done_cyc", d, 44);
    check("ign_ring_cyc", r, 43);
    check("ign_count",    bus.count, 10);
    idle(60, p, rs);
    check("ign_extra_done", p, 0);

    // Back-to-back: re-arm in the DONE cycle
    drive_start(1'b1, 40);
    measure(40, 1'b0, 1'b1, 8, d, ds, r, b);
    check("b2b_first_done_cyc", d, 44);
    check("b2b_first_count",    bus.count, 10);
    measure(8, 1'b0, 1'b0, 0, d, ds, r, b);
    check("b2b_second_done_cyc", d, 12);
    check("b2b_second_ring_cyc", r, 11);
    check("b2b_second_count",    bus.count, 2);
    idle(3, p, rs);

    // Asynchronous reset in COUNT
    drive_start(1'b1, 100);
    @(posedge clk); #1;
    drive_start(1'b0, 100);
    repeat (79) @(posedge clk);
    #1;
    check("mid_ring_en_before",    bus.ring_en, 1);
    check("mid_count_nonzero",     bus.count != 0, 1);
    check("mid_overflow_s_before", bus_s.overflow, 1);
    rst = 1'b1;
    #1;
    check("mid_ring_en",    bus.ring_en, 0);
    check("mid_busy",       bus.busy, 0);
    check("mid_count",      bus.count, 0);
    check("mid_overflow",   bus.overflow, 0);
    check("mid_count_s",    bus_s.count, 0);
    check("mid_overflow_s", bus_s.overflow, 0);
    #1;
    rst = 1'b0;
    idle(60, p, rs);
    check("mid_no_done", p, 0);
    check("mid_no_ring", rs, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
